// File: rtl/reg_mux_n_1.sv
// rtl/reg_mux_n_1.sv - registered N:1 selector with explicit or round-robin grant
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    NUM_IN packed channels, channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   sel        channel index used when mode = 0
//   mode       0 = select by sel, 1 = round-robin among valid channels
//   flush      synchronous clear of the output register
//   out_data   registered selected word
//   out_src    index of the channel held in out_data
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
module reg_mux_n_1 #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 4,
  parameter int               SEL_W     = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] cand;
  logic [WIDTH-1:0] grant_data;
  logic             can_load;
  logic             load;

  // in_ready is held low while reset is asserted, not only after the
  // first clock edge, so the reset gates the load condition directly.
  assign can_load = rst_n && !flush && (!out_valid || out_ready);
  assign load     = can_load && grant_valid;

  always_comb begin : grant_logic
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!mode) begin
      // Comparing against every legal index means a sel beyond NUM_IN-1
      // simply matches nothing and never grants.
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      // Scan from the farthest candidate to the nearest one after rr_ptr;
      // the last hit written is the nearest, which gives it priority.
      for (int k = NUM_IN; k >= 1; k--) begin
        cand = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
        if (in_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin : data_select
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : ready_decode
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = can_load && grant_valid && (grant_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= RESET_VAL;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(NUM_IN - 1);
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= RESET_VAL;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_src   <= grant_idx;
      if (mode) begin
        rr_ptr <= grant_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_mux_n_1.sv
// tb/tb_reg_mux_n_1.sv - scoreboard bench for reg_mux_n_1 (4-channel and 3-channel instances)
module tb_reg_mux_n_1;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic         mode;
  logic         flush;
  logic [31:0]  out_data;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [1:0]   sel3;
  logic         mode3;
  logic         flush3;
  logic [31:0]  out_data3;
  logic [1:0]   out_src3;
  logic         out_valid3;
  logic         out_ready3;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_mux_n_1 dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .flush(flush),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  reg_mux_n_1 #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .flush(flush3),
    .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_chans();
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hC0DE_0100 + 32'(i);
    for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'hBEEF_0000 + 32'(i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; flush = 1'b0; in_valid = 4'b0; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; flush3 = 1'b0; in_valid3 = 3'b0; out_ready3 = 1'b1;
    set_chans();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_src, out_data, in_ready} !== {1'b0, 2'd0, 32'd0, 4'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b src=%0d data=%h rdy=%b want v=0 src=0 data=0 rdy=0000",
               out_valid, out_src, out_data, in_ready);
    end
    // load a word, then assert reset mid-cycle while it is held
    sel = 2'd1; in_valid = 4'hF;
    tick();
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'hC0DE_0101}) begin
      n_fail++;
      $display("FAIL pre_reset_load: got v=%b data=%h want v=1 data=c0de0101", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, in_ready} !== {1'b0, 32'd0, 4'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b data=%h rdy=%b want v=0 data=0 rdy=0000",
               out_valid, out_data, in_ready);
    end
    tick();
    rst_n = 1'b1; in_valid = 4'b0;
    tick();
  endtask

  task automatic test_sel_mode();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    in_data[2*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL sel2_ready: got %b want 0100", in_ready);
    end
    e.src = 2'd2; e.data = 32'hDEAD_BEEF; exp_q.push_back(e);
    tick();
    sel = 2'd0;
    e = exp_q.pop_front();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, e.src, e.data}) begin
      n_fail++;
      $display("FAIL sel2_out: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
               out_valid, out_src, out_data, e.src, e.data);
    end
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL sel0_ready: got %b want 0001", in_ready);
    end
    e.src = 2'd0; e.data = 32'hC0DE_0100; exp_q.push_back(e);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, e.src, e.data}) begin
      n_fail++;
      $display("FAIL sel0_out: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
               out_valid, out_src, out_data, e.src, e.data);
    end
    set_chans();
  endtask

  task automatic test_sel_invalid();
    mode = 1'b0; sel = 2'd3; in_valid = 4'b0111; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL sel_invalid_ready: got %b want 0000", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_invalid_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    int sp[3] = '{3, 1, 3};
    mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'(1 << (k % 4))) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, 4'(1 << (k % 4)));
      end
      e.src = 2'(k % 4); e.data = 32'hC0DE_0100 + 32'(k % 4); exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({out_valid, out_src, out_data} !== {1'b1, e.src, e.data}) begin
        n_fail++;
        $display("FAIL rr_out[%0d]: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                 k, out_valid, out_src, out_data, e.src, e.data);
      end
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      e.src = 2'(sp[k]); e.data = 32'hC0DE_0100 + 32'(sp[k]); exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({out_valid, out_src, out_data} !== {1'b1, e.src, e.data}) begin
        n_fail++;
        $display("FAIL rr_sparse[%0d]: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                 k, out_valid, out_src, out_data, e.src, e.data);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    e.src = 2'd0; e.data = 32'hC0DE_0100; exp_q.push_back(e);
    tick();
    out_ready = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, e.src, e.data}) begin
      n_fail++;
      $display("FAIL bp_load: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
               out_valid, out_src, out_data, e.src, e.data);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({in_ready, out_valid, out_data} !== {4'b0, 1'b1, 32'hC0DE_0100}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b data=%h want rdy=0000 v=1 data=c0de0100",
                 k, in_ready, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 0010", in_ready);
    end
    e.src = 2'd1; e.data = 32'hC0DE_0101; exp_q.push_back(e);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, e.src, e.data}) begin
      n_fail++;
      $display("FAIL bp_release_out: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
               out_valid, out_src, out_data, e.src, e.data);
    end
  endtask

  task automatic test_flush();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_ready: got %b want 0000", in_ready);
    end
    tick();
    flush = 1'b0;
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b0, 2'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL flush_out: got v=%b src=%0d data=%h want v=0 src=0 data=0",
               out_valid, out_src, out_data);
    end
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL flush_rr_hold: got %b want 0100", in_ready);
    end
    e.src = 2'd2; e.data = 32'hC0DE_0102; exp_q.push_back(e);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, e.src, e.data}) begin
      n_fail++;
      $display("FAIL flush_next: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
               out_valid, out_src, out_data, e.src, e.data);
    end
  endtask

  task automatic test_mode_switch();
    mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    e.src = 2'd0; e.data = 32'hC0DE_0100; exp_q.push_back(e);
    tick();
    mode = 1'b1;
    e = exp_q.pop_front();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, e.src, e.data}) begin
      n_fail++;
      $display("FAIL switch_m0: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
               out_valid, out_src, out_data, e.src, e.data);
    end
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL switch_m1_ready: got %b want 1000", in_ready);
    end
    tick();
    in_valid = 4'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_narrow();
    int seq[4] = '{0, 1, 2, 0};
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    n_checks++;
    if (in_ready3 !== 3'b000) begin
      n_fail++;
      $display("FAIL n3_sel_oob_ready: got %b want 000", in_ready3);
    end
    tick();
    n_checks++;
    if (out_valid3 !== 1'b0) begin
      n_fail++;
      $display("FAIL n3_sel_oob_out: got out_valid=%b want 0", out_valid3);
    end
    sel3 = 2'd2;
    e.src = 2'd2; e.data = 32'hBEEF_0002; exp_q.push_back(e);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if ({out_valid3, out_src3, out_data3} !== {1'b1, e.src, e.data}) begin
      n_fail++;
      $display("FAIL n3_sel2: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
               out_valid3, out_src3, out_data3, e.src, e.data);
    end
    mode3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.src = 2'(seq[k]); e.data = 32'hBEEF_0000 + 32'(seq[k]); exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({out_valid3, out_src3, out_data3} !== {1'b1, e.src, e.data}) begin
        n_fail++;
        $display("FAIL n3_rr[%0d]: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                 k, out_valid3, out_src3, out_data3, e.src, e.data);
      end
    end
    in_valid3 = 3'b0;
  endtask

  initial begin
    test_reset();
    test_sel_mode();
    test_sel_invalid();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_mode_switch();
    test_narrow();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
